// File: rtl/ldl_fifo_rd_stream_if.sv
// Bus between the LDL FIFO read port, the read-stream adapter and its consumer.
// DW must match the adapter's DW.
interface ldl_fifo_rd_stream_if #(
    parameter int DW = 8
);
    logic          fifo_empty;
    logic          fifo_re;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    // Stream handshake: a word moves on a rising edge where m_valid && m_ready are both 1;
    // once m_valid is 1, m_valid and m_data hold until that edge, and m_ready may be any value.
    modport slave (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_re,
        output m_valid,
        output m_data
    );

    modport master (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_re,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/ldl_fifo_rd_stream.sv
// Drains the LDL FIFO into a registered valid/ready stream through a 2-entry skid buffer.
// Optional stall counter: define LDL_FIFO_RD_STREAM_STALL_CNT_EN.
module ldl_fifo_rd_stream #(
    parameter int DW    = 8,
    parameter bit AHEAD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ldl_fifo_rd_stream_if.slave  bus,
    output logic [1:0]           occ
`ifdef LDL_FIFO_RD_STREAM_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    logic [DW-1:0] slot0_q, slot1_q;
    logic [DW-1:0] slot0_nxt, slot1_nxt;
    logic [1:0]    occ_q, occ_nxt;
    logic          valid_q;
    logic          inflight;
    logic          push;
    logic          pop;
    logic          rd_en;
    logic [2:0]    level;

    assign pop   = valid_q & bus.m_ready;
    assign level = {1'b0, occ_q} + {2'b00, inflight};
    // Reading on a pop is safe: the word leaving makes room for the one arriving.
    assign rd_en = rst_n & ~bus.fifo_empty & ((level < 3'd2) | pop);

    assign bus.fifo_re = rd_en;
    assign bus.m_valid = valid_q;
    assign bus.m_data  = slot0_q;
    assign occ         = occ_q;

    generate
        if (AHEAD) begin : g_ahead
            assign inflight = 1'b0;
            assign push     = rd_en;
        end else begin : g_latency
            logic inflight_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    inflight_q <= 1'b0;
                end else begin
                    inflight_q <= rd_en;
                end
            end
            assign inflight = inflight_q;
            assign push     = inflight_q;
        end
    endgenerate

    always_comb begin
        occ_nxt   = occ_q;
        slot0_nxt = slot0_q;
        slot1_nxt = slot1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    slot0_nxt = bus.fifo_dout;
                end else begin
                    slot1_nxt = bus.fifo_dout;
                end
                occ_nxt = occ_q + 2'd1;
            end
            2'b01: begin
                // With only one word left, slot0 keeps its stale value instead of going unknown.
                if (occ_q == 2'd2) begin
                    slot0_nxt = slot1_q;
                end
                occ_nxt = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    slot0_nxt = slot1_q;
                    slot1_nxt = bus.fifo_dout;
                end else begin
                    slot0_nxt = bus.fifo_dout;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            slot0_q <= slot0_nxt;
            slot1_q <= slot1_nxt;
            occ_q   <= occ_nxt;
            valid_q <= (occ_nxt != 2'd0);
        end
    end

`ifdef LDL_FIFO_RD_STREAM_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if (valid_q && !bus.m_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
